// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: baud divider helper, frame shape and receiver state codes.
package uart_rx_pkg;

   // Frame shape for 8N1 links.
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   localparam int BIT_CNT_W = $clog2(DATA_BITS);

   // Receiver state encodings, kept as named codes so uart_tx and debug tools agree on them.
   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_BREAK = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = RX_IDLE,
      ST_START = RX_START,
      ST_DATA  = RX_DATA,
      ST_STOP  = RX_STOP,
      ST_BREAK = RX_BREAK
   } rx_state_t;

   // Clocks per bit period; plain integer division, so the chosen clock/baud pair must
   // leave the truncation error small enough for the far end to stay in tolerance.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit pin inputs.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give the first stage a full cycle to resolve metastability.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-byte holding register, framing-error and overrun pulses.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ     = 12_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_byte,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

   logic                 rxd_s;
   rx_state_t            state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

   // Frame FSM with its counters and all registered outputs; start is sampled at mid-bit,
   // every later bit one full bit period after the previous sample point.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         rx_byte      <= '0;
         rx_valid     <= 1'b0;
         rx_busy      <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!rxd_s) begin
                  baud_cnt <= '0;
                  rx_busy  <= 1'b1;
                  state    <= ST_START;
               end
            end

            ST_START: begin
               if (baud_cnt == CNT_HALF) begin
                  baud_cnt <= '0;
                  if (!rxd_s) begin
                     bit_cnt <= '0;
                     state   <= ST_DATA;
                  end else begin
                     rx_busy <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt  <= '0;
                  shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     state <= ST_STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_STOP: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  if (rxd_s) begin
                     rx_busy <= 1'b0;
                     state   <= ST_IDLE;
                     if (!rx_valid || rx_ready) begin
                        rx_byte  <= shift_reg;
                        rx_valid <= 1'b1;
                     end else begin
                        rx_overrun <= 1'b1;
                     end
                  end else begin
                     rx_frame_err <= 1'b1;
                     state        <= ST_BREAK;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_BREAK: begin
               if (rxd_s) begin
                  rx_busy <= 1'b0;
                  state   <= ST_IDLE;
               end
            end

            default: begin
               rx_busy <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, scoreboard of expected bytes.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int CPB = 104;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_overrun;

   int errors = 0;
   int checks = 0;
   int cycleNum = 0;
   int fallCycle = 0;
   int errCount = 0;
   int ovrCount = 0;
   int busyCount = 0;
   int lastErrCycle = -1;
   int lastOvrCycle = -1;
   int lastValidCycle = -1;
   int errBase;
   int ovrBase;
   logic [7:0] expQ[$];

   uart_rx #(.CLK_FREQ(12_000_000), .BAUD(115200)) dut (
      .clk          (clk),
      .rst          (rst),
      .rxd          (rxd),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_busy      (rx_busy),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   // Free-running clock and a cycle counter used to timestamp events.
   always #5 clk = ~clk;

   always @(posedge clk) cycleNum <= cycleNum + 1;

   // Exact-match comparison; every failure is counted and reported.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Range comparison for latencies and durations.
   task automatic checkWindow(input string tag, input int observed, input int lo, input int hi);
      checks++;
      assert (observed >= lo && observed <= hi) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
      end
   endtask

   // Hold the line at one level for a whole bit period (entered and left at posedge+1).
   task automatic driveBit(input logic b);
      rxd = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Send one 8N1 frame, LSB first, with a selectable stop-bit level.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      fallCycle = cycleNum;
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(data[i]);
      driveBit(stopBit);
   endtask

   // Bounded wait for the scoreboard to empty.
   task automatic waitDrain(input string tag);
      int n = 0;
      while (expQ.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      checkOutput(tag, expQ.size(), 0);
   endtask

   // Output monitor: pops the scoreboard on each handshake and tallies error pulses.
   always @(negedge clk) begin
      logic [7:0] exp;
      if (rx_busy === 1'b1) busyCount++;
      if (rx_frame_err === 1'b1) begin
         errCount++;
         lastErrCycle = cycleNum;
      end
      if (rx_overrun === 1'b1) begin
         ovrCount++;
         lastOvrCycle = cycleNum;
      end
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
         lastValidCycle = cycleNum;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_byte", {24'h0, rx_byte}, 32'hFFFF_FFFF);
         end else begin
            exp = expQ.pop_front();
            checkOutput("rx_byte", {24'h0, rx_byte}, {24'h0, exp});
         end
      end
   end

   // Watchdog so a stuck run still ends with a report.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Directed test sequence.
   initial begin
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset_rx_byte", {24'h0, rx_byte}, 32'h0);
      checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
      checkOutput("reset_rx_busy", {31'h0, rx_busy}, 32'h0);
      checkOutput("reset_frame_err", {31'h0, rx_frame_err}, 32'h0);
      checkOutput("reset_overrun", {31'h0, rx_overrun}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      $display("[TB] glitch: 30-cycle low pulse");
      busyCount = 0;
      rxd = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rxd = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      checkWindow("glitch_busy_cycles", busyCount, 1, 53);
      checkOutput("glitch_busy_end", {31'h0, rx_busy}, 32'h0);
      checkOutput("glitch_no_valid", {31'h0, rx_valid}, 32'h0);
      checkOutput("glitch_no_err", errCount + ovrCount, 0);

      $display("[TB] loopback 0x42");
      rx_ready = 1'b1;
      expQ.push_back(8'h42);
      applyStimulus(8'h42, 1'b1);
      waitDrain("loopback_drain");
      checkWindow("loopback_latency", lastValidCycle - fallCycle, 989, 991);
      checkOutput("loopback_no_err", errCount + ovrCount, 0);

      $display("[TB] back-to-back 00 FF A5 5A");
      expQ.push_back(8'h00);
      expQ.push_back(8'hFF);
      expQ.push_back(8'hA5);
      expQ.push_back(8'h5A);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'hA5, 1'b1);
      applyStimulus(8'h5A, 1'b1);
      waitDrain("b2b_drain");
      checkOutput("b2b_no_err", errCount + ovrCount, 0);

      $display("[TB] framing error and break");
      errBase = errCount;
      applyStimulus(8'h42, 1'b0);
      repeat (3000) @(posedge clk);
      #1;
      checkOutput("frame_err_count", errCount - errBase, 1);
      checkWindow("frame_err_latency", lastErrCycle - fallCycle, 989, 991);
      checkOutput("break_busy_held", {31'h0, rx_busy}, 32'h1);
      checkOutput("break_no_valid", {31'h0, rx_valid}, 32'h0);
      rxd = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("break_released", {31'h0, rx_busy}, 32'h0);
      expQ.push_back(8'h13);
      applyStimulus(8'h13, 1'b1);
      waitDrain("after_break_drain");
      checkOutput("after_break_err_count", errCount - errBase, 1);

      $display("[TB] overrun 0x11 then 0x22");
      rx_ready = 1'b0;
      ovrBase = ovrCount;
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("overrun_count", ovrCount - ovrBase, 1);
      checkWindow("overrun_latency", lastOvrCycle - fallCycle, 989, 991);
      checkOutput("overrun_valid", {31'h0, rx_valid}, 32'h1);
      checkOutput("overrun_kept_byte", {24'h0, rx_byte}, 32'h11);
      expQ.push_back(8'h11);
      rx_ready = 1'b1;
      waitDrain("overrun_drain");
      @(negedge clk);
      checkOutput("overrun_valid_dropped", {31'h0, rx_valid}, 32'h0);
      @(posedge clk);
      #1;

      $display("[TB] reset during bit 3");
      errBase = errCount;
      ovrBase = ovrCount;
      driveBit(1'b0);
      driveBit(1'b0);
      driveBit(1'b1);
      driveBit(1'b0);
      rxd = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      checkOutput("midframe_busy", {31'h0, rx_busy}, 32'h1);
      rst = 1'b1;
      rxd = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_rx_byte", {24'h0, rx_byte}, 32'h0);
      checkOutput("midreset_rx_valid", {31'h0, rx_valid}, 32'h0);
      checkOutput("midreset_rx_busy", {31'h0, rx_busy}, 32'h0);
      checkOutput("midreset_pulses", {30'h0, rx_frame_err, rx_overrun}, 32'h0);
      @(posedge clk);
      #1;
      repeat (200) @(posedge clk);
      #1;
      checkOutput("midreset_no_pulses", (errCount - errBase) + (ovrCount - ovrBase), 0);
      expQ.push_back(8'h37);
      applyStimulus(8'h37, 1'b1);
      waitDrain("after_reset_drain");
      checkOutput("after_reset_no_err", (errCount - errBase) + (ovrCount - ovrBase), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
